// File: rtl/aes_key_expansion_pkg.sv
// Shared AES-128 constants, FSM encoding and the forward S-box used by the key schedule.
// The S-box lives here so a future encryptor can reuse the same table.
package aes_key_expansion_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int SEL_W      = 4;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Round constants for rounds 1..10, round 1 in the top byte.
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sboxLookup(input logic [7:0] x);
    logic [7:0] inv;
    inv = ~x;
    return SBOX_TABLE[{inv, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] getRcon(input logic [3:0] round);
    logic [7:0] rcon;
    rcon = 8'h00;
    if (round >= 4'd1 && round <= LAST_ROUND) begin
      rcon = RCON_TABLE[{3'd0, LAST_ROUND - round, 3'b000} +: 8];
    end
    return rcon;
  endfunction

endpackage

// File: rtl/aes_key_expansion_if.sv
// Bus between the AES decryptor (master) and the key schedule (slave).
interface aes_key_expansion_if;
  import aes_key_expansion_pkg::*;

  logic             start;
  logic [127:0]     cipherKey;
  logic [SEL_W-1:0] selKey;
  logic [127:0]     key;
  logic             busy;
  logic             ry;

  modport master (
    output start, cipherKey, selKey,
    input  key, busy, ry
  );

  modport slave (
    input  start, cipherKey, selKey,
    output key, busy, ry
  );

endinterface

// File: rtl/aes_key_expansion_sbox.sv
// Combinational forward AES S-box, one byte in and one byte out.
module aes_sbox
  import aes_key_expansion_pkg::*;
(
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  assign o_data = sboxLookup(i_data);

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands the cipher key into 11 round keys, one per clock,
// and serves them to the decryptor by index once the whole schedule is valid.
module aes_key_expansion
  import aes_key_expansion_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  aes_key_expansion_if.slave  bus
);

  state_t       r_state;
  state_t       w_nextState;
  logic [3:0]   r_round;
  logic [127:0] r_keys [NUM_ROUNDS+1];
  logic         r_ry;

  logic         w_load;
  logic         w_write;
  logic [127:0] w_prevKey;
  logic [127:0] w_nextKey;
  logic [31:0]  w_rotWord;
  logic [31:0]  w_subWord;
  logic [31:0]  w_temp;
  logic [31:0]  w_word0;
  logic [31:0]  w_word1;
  logic [31:0]  w_word2;
  logic [31:0]  w_word3;

  assign w_prevKey = r_keys[r_round - 4'd1];
  assign w_rotWord = {w_prevKey[23:0], w_prevKey[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subWord
    aes_sbox u_sbox (
      .i_data (w_rotWord[8*i +: 8]),
      .o_data (w_subWord[8*i +: 8])
    );
  end

  assign w_temp    = w_subWord ^ {getRcon(r_round), 24'h0};
  assign w_word0   = w_prevKey[127:96] ^ w_temp;
  assign w_word1   = w_prevKey[95:64]  ^ w_word0;
  assign w_word2   = w_prevKey[63:32]  ^ w_word1;
  assign w_word3   = w_prevKey[31:0]   ^ w_word2;
  assign w_nextKey = {w_word0, w_word1, w_word2, w_word3};

  // Start is only honoured when no expansion is running.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_nextState = EXPAND;
          w_load      = 1'b1;
        end
      end
      EXPAND: begin
        w_write = 1'b1;
        if (r_round == LAST_ROUND) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Ry lags entry to DONE by one cycle so it never overlaps Busy, and drops on restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_round <= 4'd0;
      r_ry    <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        r_keys[i] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      r_ry    <= (r_state == DONE) && (w_nextState == DONE);
      if (w_load) begin
        r_keys[0] <= bus.cipherKey;
        r_round   <= 4'd1;
      end else if (w_write) begin
        r_keys[r_round] <= w_nextKey;
        r_round         <= r_round + 4'd1;
      end
    end
  end

  always_comb begin
    bus.key = '0;
    if (r_ry && bus.selKey <= LAST_ROUND) begin
      bus.key = r_keys[bus.selKey];
    end
  end

  assign bus.busy = (r_state == EXPAND);
  assign bus.ry   = r_ry;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for the AES-128 key schedule using FIPS-197 and all-zero key vectors.
module tb_aes_key_expansion;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_KEYS [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_KEY1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_KEY10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expansion_if bus ();

  aes_key_expansion dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [127:0] key);
    bus.start     = start;
    bus.cipherKey = key;
  endtask

  // Start an expansion and follow it cycle by cycle; optionally inject a second Start
  // at glitchCycle or an async reset at resetCycle.
  task automatic runExpansion(input logic [127:0] key, input int glitchCycle, input int resetCycle);
    bus.selKey = 4'd0;
    applyStimulus(1'b1, key);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) begin
        if (k == glitchCycle) applyStimulus(1'b1, 128'h0);
        tick();
        bus.start = 1'b0;
      end
      if (k == resetCycle) begin
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput($sformatf("rstBusy@%0d", k), {127'b0, bus.busy}, 128'h0);
        checkOutput($sformatf("rstRy@%0d", k), {127'b0, bus.ry}, 128'h0);
        checkOutput($sformatf("rstKey@%0d", k), bus.key, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 15; j++) begin
          tick();
          checkOutput($sformatf("postRstRy@%0d", j), {127'b0, bus.ry}, 128'h0);
          checkOutput($sformatf("postRstBusy@%0d", j), {127'b0, bus.busy}, 128'h0);
        end
        return;
      end
      checkOutput($sformatf("busy@%0d", k), {127'b0, bus.busy}, {127'b0, (k < 10)});
      checkOutput($sformatf("ry@%0d", k), {127'b0, bus.ry}, {127'b0, (k == 11)});
      if (k <= 10) checkOutput($sformatf("keyHidden@%0d", k), bus.key, 128'h0);
    end
  endtask

  task automatic sweepFips();
    for (int sel = 0; sel < 16; sel++) begin
      bus.selKey = 4'(sel);
      #1;
      checkOutput($sformatf("sel%0d", sel), bus.key, (sel <= 10) ? FIPS_KEYS[sel] : 128'h0);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    bus.selKey = 4'd0;
    applyStimulus(1'b0, 128'h0);
    #3;
    checkOutput("resetBusy", {127'b0, bus.busy}, 128'h0);
    checkOutput("resetRy", {127'b0, bus.ry}, 128'h0);
    checkOutput("resetKey", bus.key, 128'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] FIPS-197 key schedule");
    runExpansion(FIPS_KEY, -1, -1);
    sweepFips();

    $display("[TB] restart from DONE with all-zero key");
    runExpansion(128'h0, -1, -1);
    bus.selKey = 4'd0;
    #1;
    checkOutput("zeroSel0", bus.key, 128'h0);
    bus.selKey = 4'd1;
    #1;
    checkOutput("zeroSel1", bus.key, ZERO_KEY1);
    bus.selKey = 4'd10;
    #1;
    checkOutput("zeroSel10", bus.key, ZERO_KEY10);

    $display("[TB] Start during expansion is ignored");
    runExpansion(FIPS_KEY, 5, -1);
    sweepFips();

    $display("[TB] async reset mid-expansion");
    runExpansion(FIPS_KEY, -1, 6);

    $display("[TB] fresh expansion after reset");
    runExpansion(128'h0, -1, -1);
    bus.selKey = 4'd10;
    #1;
    checkOutput("afterRstSel10", bus.key, ZERO_KEY10);
    bus.selKey = 4'd11;
    #1;
    checkOutput("afterRstSel11", bus.key, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
